// File: rtl/iris_fpga_fw_metadata_pkg.sv
// Shared types and constants for the Iris firmware-metadata responder and
// the CRC-8 helper used by other telemetry blocks.
package iris_fw_meta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CRC  = 2'd2
  } state_t;

  localparam logic [7:0]  CRC8_POLY           = 8'h07;
  localparam int unsigned HDR_BYTES           = 2;
  localparam int unsigned FIXED_PAYLOAD_BYTES = 7;
  localparam int unsigned MAX_USER_BYTES      = 16;

endpackage

// File: rtl/iris_crc8_step.sv
// One-byte CRC-8 update (poly CRC8_POLY, MSB first, no reflection, no final XOR).
module iris_crc8_step
  import iris_fw_meta_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/iris_fpga_fw_metadata.sv
// Streams MAGIC, LEN, version, build ID and latched user bytes over valid/ready.
// Define IRIS_FW_META_CRC_EN to append a CRC-8 trailer byte to every frame.
module iris_fpga_fw_metadata
  import iris_fw_meta_pkg::*;
#(
  parameter logic [7:0]  FW_VER_MAJ     = 8'd11,
  parameter logic [7:0]  FW_VER_MIN     = 8'd0,
  parameter logic [7:0]  FW_VER_PATCH   = 8'd3,
  parameter logic [31:0] BUILD_ID       = 32'h0000_0000,
  parameter int unsigned NUM_USER_BYTES = 4,
  parameter logic [7:0]  MAGIC          = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req,
  input  logic [8*NUM_USER_BYTES-1:0] user_data,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        req_dropped,
  output logic [7:0]                  major,
  output logic [7:0]                  minor,
  output logic [7:0]                  patch
);

  localparam int unsigned BODY_BYTES = HDR_BYTES + FIXED_PAYLOAD_BYTES + NUM_USER_BYTES;
  localparam int unsigned MAX_FRAME  = HDR_BYTES + FIXED_PAYLOAD_BYTES + MAX_USER_BYTES + 1;
  localparam int unsigned IDX_W      = $clog2(MAX_FRAME);
  localparam int unsigned USER_BASE  = HDR_BYTES + FIXED_PAYLOAD_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BODY_BYTES - 1);
  localparam logic [7:0]       LEN      = 8'(FIXED_PAYLOAD_BYTES + NUM_USER_BYTES);

  state_t                      state, state_next;
  logic [IDX_W-1:0]            idx;
  logic [8*NUM_USER_BYTES-1:0] shadow;
  logic [7:0]                  body [BODY_BYTES];
  logic [7:0]                  body_byte;
  logic                        xfer;
  logic                        accept;

  assign major  = FW_VER_MAJ;
  assign minor  = FW_VER_MIN;
  assign patch  = FW_VER_PATCH;
  assign xfer   = out_valid && out_ready;
  assign accept = (state == IDLE) && req;

`ifdef IRIS_FW_META_CRC_EN
  logic [7:0] crc, crc_next;

  iris_crc8_step u_crc8 (
    .crc_in  (crc),
    .data_in (body_byte),
    .crc_out (crc_next)
  );
`endif

  // Header, payload and user bytes laid out by frame position.
  always_comb begin
    body[0] = MAGIC;
    body[1] = LEN;
    body[2] = FW_VER_MAJ;
    body[3] = FW_VER_MIN;
    body[4] = FW_VER_PATCH;
    body[5] = BUILD_ID[31:24];
    body[6] = BUILD_ID[23:16];
    body[7] = BUILD_ID[15:8];
    body[8] = BUILD_ID[7:0];
    for (int unsigned i = 0; i < NUM_USER_BYTES; i++) begin
      body[USER_BASE + i] = shadow[8*(NUM_USER_BYTES - i) - 1 -: 8];
    end
  end

  always_comb begin
    body_byte = '0;
    for (int unsigned i = 0; i < BODY_BYTES; i++) begin
      if (idx == IDX_W'(i)) body_byte = body[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req) state_next = SEND;
      SEND: begin
        if (xfer && idx == LAST_IDX) begin
`ifdef IRIS_FW_META_CRC_EN
          state_next = CRC;
`else
          state_next = IDLE;
`endif
        end
      end
      CRC:     if (xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = body_byte;
`ifndef IRIS_FW_META_CRC_EN
        out_last  = (idx == LAST_IDX);
`endif
      end
      CRC: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = 1'b1;
`ifdef IRIS_FW_META_CRC_EN
        out_data  = crc;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      shadow      <= '0;
      done        <= 1'b0;
      req_dropped <= 1'b0;
`ifdef IRIS_FW_META_CRC_EN
      crc         <= '0;
`endif
    end else begin
      done        <= (state != IDLE) && (state_next == IDLE);
      req_dropped <= req && busy;
      if (accept) begin
        shadow <= user_data;
        idx    <= '0;
`ifdef IRIS_FW_META_CRC_EN
        crc    <= '0;
`endif
      end else if (state == SEND && xfer) begin
        // Index parks on the final position; the FSM leaves SEND there.
        if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
`ifdef IRIS_FW_META_CRC_EN
        crc <= crc_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_iris_fpga_fw_metadata.sv
// Scoreboard bench for iris_fpga_fw_metadata (N=4 main instance, N=1 and N=16 side instances).
module tb_iris_fpga_fw_metadata;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

`ifdef IRIS_FW_META_CRC_EN
  localparam int CRC_EXTRA = 1;
`else
  localparam int CRC_EXTRA = 0;
`endif
  localparam int FL0 = 13 + CRC_EXTRA;
  localparam int FL1 = 10 + CRC_EXTRA;
  localparam int FL2 = 25 + CRC_EXTRA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req0, req1, req2;
  logic rdy0, rdy1, rdy2;
  logic [31:0]  ud0;
  logic [7:0]   ud1;
  logic [127:0] ud2;

  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, l0, l1, l2, b0, b1, b2, dn0, dn1, dn2, rd0, rd1, rd2;
  logic [7:0] maj0, min0, pat0, maj1, min1, pat1, maj2, min2, pat2;

  iris_fpga_fw_metadata #(.BUILD_ID(32'h12345678)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .user_data(ud0),
    .out_data(d0), .out_valid(v0), .out_ready(rdy0), .out_last(l0),
    .busy(b0), .done(dn0), .req_dropped(rd0),
    .major(maj0), .minor(min0), .patch(pat0));

  iris_fpga_fw_metadata #(.BUILD_ID(32'h12345678), .NUM_USER_BYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .user_data(ud1),
    .out_data(d1), .out_valid(v1), .out_ready(rdy1), .out_last(l1),
    .busy(b1), .done(dn1), .req_dropped(rd1),
    .major(maj1), .minor(min1), .patch(pat1));

  iris_fpga_fw_metadata #(.BUILD_ID(32'h12345678), .NUM_USER_BYTES(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .user_data(ud2),
    .out_data(d2), .out_valid(v2), .out_ready(rdy2), .out_last(l2),
    .busy(b2), .done(dn2), .req_dropped(rd2),
    .major(maj2), .minor(min2), .patch(pat2));

  logic [7:0] ci, di, co;
  iris_crc8_step u_crc (.crc_in(ci), .data_in(di), .crc_out(co));

  exp_t q0[$], q1[$], q2[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference: one input bit at a time into the shift register.
  function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r = c;
    for (int b = 7; b >= 0; b--) begin
      logic fb = r[7] ^ d[b];
      r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  task automatic push_frame(input int id, input int n, input logic [127:0] ud);
    logic [7:0] b[$];
    logic [7:0] c = 8'h00;
    exp_t e;
    b = '{8'hA5, 8'(7 + n), 8'h0B, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < n; i++) b.push_back(ud[8*(n-i)-1 -: 8]);
`ifdef IRIS_FW_META_CRC_EN
    foreach (b[i]) c = crc8_ref(c, b[i]);
    b.push_back(c);
`endif
    foreach (b[i]) begin
      e.data = b[i];
      e.last = (i == b.size() - 1);
      case (id)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  logic [8:0] held[3];
  bit         stall[3];

  task automatic mon(input int id, input logic v, input logic r, input logic [7:0] d, input logic l);
    exp_t e;
    bit   empty;
    if (stall[id]) begin
      chk($sformatf("valid_hold_dut%0d", id), v, 1);
      chk($sformatf("data_hold_dut%0d", id), {d, l}, held[id]);
    end
    if (v && r) begin
      empty = 1'b0;
      case (id)
        0: if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
        1: if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
        default: if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front();
      endcase
      if (empty) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte dut%0d: got %02h last %0b, no byte expected", id, d, l);
      end else begin
        chk($sformatf("byte_dut%0d", id), {d, l}, {e.data, e.last});
      end
    end
    stall[id] = v && !r;
    held[id]  = {d, l};
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      foreach (stall[i]) stall[i] = 1'b0;
    end else begin
      mon(0, v0, rdy0, d0, l0);
      mon(1, v1, rdy1, d1, l1);
      mon(2, v2, rdy2, d2, l2);
    end
  end

  task automatic wait_done(input int id, input bit bp, output int cyc);
    bit seen = 1'b0;
    logic dn;
    cyc = 0;
    while (!seen && cyc < 400) begin
      if (bp) rdy0 = (cyc % 4 == 0) || (cyc % 4 == 3);
      @(posedge clk);
      #1;
      cyc++;
      case (id)
        0: dn = dn0;
        1: dn = dn1;
        default: dn = dn2;
      endcase
      if (dn === 1'b1) seen = 1'b1;
    end
    rdy0 = 1'b1;
    chk($sformatf("done_seen_dut%0d", id), seen, 1);
  endtask

  task automatic start0();
    push_frame(0, 4, {96'h0, ud0});
    req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
  endtask

  logic [7:0] msg [9];
  int cyc;

  initial begin
    rst_n = 1'b0;
    req0 = 0; req1 = 0; req2 = 0;
    rdy0 = 1; rdy1 = 1; rdy2 = 1;
    ud0 = 32'hDEADBEEF;
    ud1 = 8'h5C;
    ud2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    ci = 8'h00;
    di = 8'h00;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", v0, 0);
    chk("rst_last", l0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_dropped", rd0, 0);
    chk("rst_data", d0, 8'h00);
    chk("major", maj0, 8'h0B);
    chk("minor", min0, 8'h00);
    chk("patch", pat0, 8'h03);

    for (int i = 0; i < 9; i++) begin
      di = msg[i];
      #1;
      ci = co;
    end
    chk("crc8_check_123456789", ci, 8'hF4);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_valid", v0, 0);

    // Plain frame, sink always ready.
    start0();
    chk("first_valid", v0, 1);
    chk("first_byte", d0, 8'hA5);
    chk("first_busy", b0, 1);
    wait_done(0, 0, cyc);
    chk("frame_cycles", cyc, FL0);
    chk("done_busy_low", b0, 0);
    chk("q0_empty_t1", q0.size(), 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", dn0, 0);

    // Backpressure 1,0,0,1.
    start0();
    wait_done(0, 1, cyc);
    chk("q0_empty_bp", q0.size(), 0);

    // Dropped request mid-frame; user_data changes after accept.
    start0();
    ud0 = 32'h0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
    chk("drop_pulse", rd0, 1);
    chk("drop_still_busy", b0, 1);
    @(posedge clk);
    #1;
    chk("drop_clear", rd0, 0);
    wait_done(0, 0, cyc);
    chk("q0_empty_drop", q0.size(), 0);
    @(posedge clk);
    #1;
    chk("no_restart", v0, 0);
    ud0 = 32'hDEADBEEF;

    // Reset mid-frame while stalled at index 7.
    start0();
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rdy0 = 1'b0;
    @(posedge clk);
    #1;
    chk("stall_idx7_byte", d0, 8'h56);
    rst_n = 1'b0;
    #1;
    q0.delete();
    chk("abort_valid", v0, 0);
    chk("abort_last", l0, 0);
    chk("abort_busy", b0, 0);
    chk("abort_data", d0, 8'h00);
    chk("abort_dropped", rd0, 0);
    @(posedge clk);
    #1;
    chk("abort_no_done", dn0, 0);
    chk("abort_valid_after", v0, 0);
    rst_n = 1'b1;
    rdy0 = 1'b1;
    @(posedge clk);
    #1;
    start0();
    chk("post_rst_first", d0, 8'hA5);
    wait_done(0, 0, cyc);
    chk("post_rst_cycles", cyc, FL0);
    chk("q0_empty_rst", q0.size(), 0);

    // req held high: next frame accepted in the done cycle.
    push_frame(0, 4, {96'h0, ud0});
    req0 = 1'b1;
    @(posedge clk);
    #1;
    push_frame(0, 4, {96'h0, ud0});
    wait_done(0, 0, cyc);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    chk("b2b_valid", v0, 1);
    chk("b2b_first", d0, 8'hA5);
    wait_done(0, 0, cyc);
    chk("b2b_cycles", cyc, FL0);
    chk("q0_empty_b2b", q0.size(), 0);
    @(posedge clk);
    #1;
    chk("b2b_one_frame", v0, 0);

    // Boundary user-byte counts.
    push_frame(1, 1, {120'h0, ud1});
    req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    wait_done(1, 0, cyc);
    chk("n1_cycles", cyc, FL1);
    chk("q1_empty", q1.size(), 0);

    push_frame(2, 16, ud2);
    req2 = 1'b1;
    @(posedge clk);
    #1;
    req2 = 1'b0;
    wait_done(2, 0, cyc);
    chk("n16_cycles", cyc, FL2);
    chk("q2_empty", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
